// File: rtl/ifu_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package ifu_fetch_pkg;

    localparam int unsigned Hold_Flag_Bus = 3;
    localparam int unsigned InstBus       = 32;
    localparam int unsigned InstAddrBus   = 32;

    // Pipeline hold level at which the fetch stage freezes.
    localparam logic [Hold_Flag_Bus-1:0] Hold_If = 3'b010;

    localparam logic [InstBus-1:0]     INST_NOP = 32'h0000_0013;
    localparam logic [InstAddrBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic [6:0] INST_TYPE_JAL = 7'b1101111;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    // One buffered fetch result handed to IF/ID.
    typedef struct packed {
        logic [InstBus-1:0]     inst;
        logic [InstAddrBus-1:0] addr;
        logic                   prdt;
    } fetch_buf_t;

endpackage

// File: rtl/ifu_static_bp.sv
// Static BTFN predictor: JAL always taken, backward conditional branches taken.
module ifu_static_bp
    import ifu_fetch_pkg::*;
(
    input  logic [InstBus-1:0]     w,
    input  logic [InstAddrBus-1:0] pc,
    output logic                   taken,
    output logic [InstAddrBus-1:0] next_pc
);

    logic [InstAddrBus-1:0] imm_j;
    logic [InstAddrBus-1:0] imm_b;
    logic [InstAddrBus-1:0] target;
    logic                   is_jal;
    logic                   is_bwd_b;

    // Decode immediates and pick the predicted successor address.
    always_comb begin
        imm_j    = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        imm_b    = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        is_jal   = (w[6:0] == INST_TYPE_JAL);
        is_bwd_b = (w[6:0] == INST_TYPE_B) && w[31];
        taken    = is_jal | is_bwd_b;
        target   = pc + (is_jal ? imm_j : imm_b);
        next_pc  = taken ? {target[InstAddrBus-1:2], 2'b00}
                         : pc + InstAddrBus'(4);
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, single-outstanding ibus request, one-entry buffer.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = ifu_fetch_pkg::INST_NOP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     jump_flag_i,
    input  logic [InstAddrBus-1:0]   jump_addr_i,
    input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
    input  logic                     stall_flag_i,
    output logic                     ibus_req_o,
    output logic [InstAddrBus-1:0]   ibus_addr_o,
    input  logic                     ibus_gnt_i,
    input  logic                     ibus_rvalid_i,
    input  logic [InstBus-1:0]       ibus_rdata_i,
    output logic [InstBus-1:0]       inst_o,
    output logic [InstAddrBus-1:0]   inst_addr_o,
    output logic                     prdt_taken_o,
    output logic                     inst_valid_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    fetch_buf_t             buf_q, buf_d;
    logic                   buf_valid_q, buf_valid_d;

    logic                   hold_en;
    logic                   accept;
    logic                   req;
    logic                   bp_taken;
    logic [InstAddrBus-1:0] bp_next;

    ifu_static_bp u_bp (
        .w       (ibus_rdata_i),
        .pc      (pc_q),
        .taken   (bp_taken),
        .next_pc (bp_next)
    );

    assign hold_en = (hold_flag_i >= Hold_If);
    assign accept  = buf_valid_q & ~stall_flag_i & ~hold_en;

    // State, PC and buffer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_q       <= '{inst: INST_NOP, addr: ZeroWord, prdt: 1'b0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end

    // Next-state, PC update, buffer fill/consume; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        req         = 1'b0;

        if (state_q == S_REQ) begin
            req = ~buf_valid_q | accept;
        end

        if (accept) begin
            buf_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (req && ibus_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ibus_rvalid_i) begin
                    buf_d       = '{inst: ibus_rdata_i, addr: pc_q, prdt: bp_taken};
                    buf_valid_d = 1'b1;
                    pc_d        = bp_next;
                    state_d     = S_REQ;
                end
            end
            S_DROP: begin
                if (ibus_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (jump_flag_i) begin
            pc_d        = {jump_addr_i[InstAddrBus-1:2], 2'b00};
            buf_d       = buf_q;
            buf_valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = (req && ibus_gnt_i) ? S_DROP : S_REQ;
                S_WAIT,
                S_DROP:  state_d = ibus_rvalid_i ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    assign ibus_req_o   = rst & req;
    assign ibus_addr_o  = pc_q;
    assign inst_valid_o = buf_valid_q;

    // Bubble whenever the buffer is empty.
    assign inst_o       = buf_valid_q ? buf_q.inst : INST_NOP;
    assign inst_addr_o  = buf_valid_q ? buf_q.addr : ZeroWord;
    assign prdt_taken_o = buf_valid_q ? buf_q.prdt : 1'b0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: bus model, scoreboard of delivered instructions, vector table.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [2:0]  HOLD_IF = 3'd2;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic        stall_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        prdt_taken_o;
    logic        inst_valid_o;

    ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .stall_flag_i  (stall_flag_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .prdt_taken_o  (prdt_taken_o),
        .inst_valid_o  (inst_valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        prdt;
    } exp_t;

    typedef struct {
        logic [31:0] jaddr;
        logic [31:0] addr;
        logic [31:0] word;
        logic        taken;
        logic [31:0] next;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic [31:0] mem [logic [31:0]];

    // Bus model state
    int          gnt_delay = 0;
    int          rv_delay  = 1;
    int          gnt_wait  = 0;
    int          pend_cnt  = 0;
    logic        pend       = 1'b0;
    logic        pend_stale = 1'b0;
    logic [31:0] pend_addr  = '0;
    logic [31:0] exp_pc     = RST_PC;
    logic        last_gnt   = 1'b0;
    logic [31:0] last_gnt_addr = '0;

    vec_t vecs [9];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return NOP;
    endfunction

    // Reference BTFN predictor.
    function automatic void model_pred(input logic [31:0] pc, input logic [31:0] w,
                                       output logic tk, output logic [31:0] nx);
        int off;
        tk = 1'b0;
        nx = pc + 32'd4;
        if (w[6:0] == 7'h6F) begin
            off = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            tk  = 1'b1;
            nx  = pc + 32'(off);
        end else if (w[6:0] == 7'h63 && w[31]) begin
            off = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            tk  = 1'b1;
            nx  = pc + 32'(off);
        end
        if (tk) nx[1:0] = 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // One clock: drive bus, score consumed instruction, advance models. Entered and left at negedge.
    task automatic step();
        logic        g, rv, j, r, acc;
        logic [31:0] a, jd, word, nx;
        logic        tk;
        exp_t        e;
        #1;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'hDEAD_BEEF;
        if (pend && pend_cnt == 0) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = mem_rd(pend_addr);
        end
        if (ibus_req_o && gnt_wait >= gnt_delay) ibus_gnt_i = 1'b1;
        #1;
        g    = ibus_gnt_i;
        rv   = ibus_rvalid_i;
        word = ibus_rdata_i;
        j    = jump_flag_i;
        jd   = jump_addr_i;
        r    = ibus_req_o;
        a    = ibus_addr_o;
        acc  = rst && inst_valid_o && !stall_flag_i && (hold_flag_i < HOLD_IF);
        if (acc) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got instruction %h at %h, expected none", inst_o, inst_addr_o);
            end else begin
                e = sb.pop_front();
                check("sb_inst", inst_o, e.inst);
                check("sb_inst_addr", inst_addr_o, e.addr);
                check("sb_prdt", {31'b0, prdt_taken_o}, {31'b0, e.prdt});
            end
        end
        if (g) check("fetch_addr", a, exp_pc);
        last_gnt      = g;
        last_gnt_addr = a;
        @(posedge clk);
        if (!rst) begin
            pend       = 1'b0;
            pend_stale = 1'b0;
            gnt_wait   = 0;
            exp_pc     = RST_PC;
            sb.delete();
        end else begin
            if (rv) begin
                pend = 1'b0;
                if (!pend_stale && !j) begin
                    model_pred(pend_addr, word, tk, nx);
                    sb.push_back('{inst: word, addr: pend_addr, prdt: tk});
                    exp_pc = nx;
                end
            end else if (pend) begin
                pend_cnt--;
            end
            if (j) begin
                exp_pc = {jd[31:2], 2'b00};
                sb.delete();
                if (pend) pend_stale = 1'b1;
            end
            if (g) begin
                pend       = 1'b1;
                pend_addr  = a;
                pend_cnt   = rv_delay - 1;
                pend_stale = j;
                gnt_wait   = 0;
            end else if (r) begin
                gnt_wait++;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 40; k++) begin
            if (inst_valid_o) break;
            step();
        end
        check(name, {31'b0, inst_valid_o}, 32'd1);
    endtask

    task automatic wait_gnt(input string name);
        for (int k = 0; k < 40; k++) begin
            step();
            if (last_gnt) break;
        end
        check(name, {31'b0, last_gnt}, 32'd1);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_inst"}, inst_o, NOP);
        check({tag, "_addr"}, inst_addr_o, 32'd0);
        check({tag, "_prdt"}, {31'b0, prdt_taken_o}, 32'd0);
        check({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
    endtask

    logic [31:0] keep_inst, keep_addr;

    initial begin
        rst          = 1'b0;
        jump_flag_i  = 1'b0;
        jump_addr_i  = '0;
        hold_flag_i  = '0;
        stall_flag_i = 1'b0;
        ibus_gnt_i   = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i = '0;

        vecs[0] = '{jaddr: 32'h00, addr: 32'h00, word: 32'h0000_0093, taken: 1'b0, next: 32'h04};
        vecs[1] = '{jaddr: 32'h08, addr: 32'h08, word: 32'h0100_006F, taken: 1'b1, next: 32'h18};
        vecs[2] = '{jaddr: 32'h20, addr: 32'h20, word: 32'hFE00_0CE3, taken: 1'b1, next: 32'h18};
        vecs[3] = '{jaddr: 32'h20, addr: 32'h20, word: 32'h0000_0463, taken: 1'b0, next: 32'h24};
        vecs[4] = '{jaddr: 32'h10, addr: 32'h10, word: 32'hFFDF_F06F, taken: 1'b1, next: 32'h0C};
        vecs[5] = '{jaddr: 32'h30, addr: 32'h30, word: 32'h0000_80E7, taken: 1'b0, next: 32'h34};
        vecs[6] = '{jaddr: 32'h00, addr: 32'h00, word: 32'hFE00_0EE3, taken: 1'b1, next: 32'hFFFF_FFFC};
        vecs[7] = '{jaddr: 32'h44, addr: 32'h44, word: 32'hFE00_1EE3, taken: 1'b1, next: 32'h40};
        vecs[8] = '{jaddr: 32'h103, addr: 32'h100, word: 32'h0000_0093, taken: 1'b0, next: 32'h104};

        mem[32'h0] = 32'h0000_0093;
        mem[32'h4] = 32'h0000_0093;

        // Reset state
        @(negedge clk);
        step();
        step();
        check_bubble("reset");
        check("reset_req", {31'b0, ibus_req_o}, 32'd0);

        // First fetches from RESET_PC with a zero-wait bus
        rst = 1'b1;
        #1;
        check("first_req", {31'b0, ibus_req_o}, 32'd1);
        check("first_addr", ibus_addr_o, RST_PC);
        step();
        check("wait_req", {31'b0, ibus_req_o}, 32'd0);
        check("wait_valid", {31'b0, inst_valid_o}, 32'd0);
        step();
        check("first_inst", inst_o, 32'h0000_0093);
        check("first_inst_addr", inst_addr_o, 32'h0);
        check("first_prdt", {31'b0, prdt_taken_o}, 32'd0);
        #1;
        check("second_req", {31'b0, ibus_req_o}, 32'd1);
        check("second_addr", ibus_addr_o, 32'h4);

        // Vector table: redirect to an address, check decoded prediction and next fetch
        for (int i = 0; i < 9; i++) begin
            gnt_delay = i % 3;
            rv_delay  = 1 + (i % 2);
            mem[vecs[i].addr] = vecs[i].word;
            jump_flag_i = 1'b1;
            jump_addr_i = vecs[i].jaddr;
            step();
            jump_flag_i = 1'b0;
            wait_valid("vec_valid");
            check("vec_addr", inst_addr_o, vecs[i].addr);
            check("vec_inst", inst_o, vecs[i].word);
            check("vec_prdt", {31'b0, prdt_taken_o}, {31'b0, vecs[i].taken});
            wait_gnt("vec_gnt");
            check("vec_next", last_gnt_addr, vecs[i].next);
        end
        mem[32'h0] = 32'h0000_0093;

        // Flush while waiting: stale response dropped, refetch at target
        gnt_delay = 0;
        rv_delay  = 3;
        for (int k = 0; k < 3; k++) step();
        wait_gnt("drop_gnt");
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h100;
        step();
        jump_flag_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("drop_valid", {31'b0, inst_valid_o}, 32'd0);
            #1;
            check("drop_req", {31'b0, ibus_req_o}, 32'd0);
            step();
        end
        check("drop_valid_after", {31'b0, inst_valid_o}, 32'd0);
        #1;
        check("drop_req_after", {31'b0, ibus_req_o}, 32'd1);
        check("drop_addr_after", ibus_addr_o, 32'h100);

        // Stall then hold with a buffered instruction
        rv_delay = 1;
        for (int pass = 0; pass < 2; pass++) begin
            wait_valid("freeze_valid");
            if (pass == 0) stall_flag_i = 1'b1;
            else           hold_flag_i  = HOLD_IF;
            keep_inst = inst_o;
            keep_addr = inst_addr_o;
            for (int k = 0; k < 3; k++) begin
                #1;
                check("freeze_req", {31'b0, ibus_req_o}, 32'd0);
                check("freeze_inst", inst_o, keep_inst);
                check("freeze_addr", inst_addr_o, keep_addr);
                step();
            end
            stall_flag_i = 1'b0;
            hold_flag_i  = 3'd0;
            #1;
            check("resume_req", {31'b0, ibus_req_o}, 32'd1);
            check("resume_addr", ibus_addr_o, exp_pc);
            step();
        end

        // Reset in the middle of a slow transaction
        gnt_delay = 4;
        rv_delay  = 2;
        wait_gnt("slow_gnt");
        rst = 1'b0;
        step();
        check_bubble("midrst");
        #1;
        check("midrst_req", {31'b0, ibus_req_o}, 32'd0);
        step();
        rst       = 1'b1;
        gnt_delay = 0;
        rv_delay  = 1;
        #1;
        check("restart_req", {31'b0, ibus_req_o}, 32'd1);
        check("restart_addr", ibus_addr_o, RST_PC);
        wait_valid("restart_valid");
        check("restart_inst_addr", inst_addr_o, RST_PC);
        check("restart_inst", inst_o, 32'h0000_0093);

        for (int k = 0; k < 6; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
